freq_meter_top: RTL and testbench
=================================

Name: freq_meter_top

Overview:
Equal-precision (reciprocal-gated) frequency meter. Runs entirely in the sys_clk domain.
- A software gate is aligned to edges of the measured input clk_test, producing a real gate.
- The number of whole test periods (X) and sys_clk cycles (Y) inside the real gate are counted.
- The output is freq = CLK_FREQ*X/Y in Hz, computed by a sequential divider.
- The block also emits clk_out, a divided sys_clk used as an on-board test source.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz (standard clock).
CNT_GATE_S_MAX, 74_999_999, last value of the measurement-period counter; period = CNT_GATE_S_MAX+1 cycles.
CNT_RISE_MAX, 12_499_999, guard cycles before and after the software gate.
CLK_OUT_DIV, 10, even divide ratio sys_clk->clk_out.

Ports:
sys_clk  in  1  system/standard clock; all logic on its rising edge.
sys_rst  in  1  reset; synchronous, active-high.
clk_test  in  1  clock under measurement; asynchronous; must be < CLK_FREQ/2.
clk_out  out  1  generated test clock, sys_clk/CLK_OUT_DIV, 50% duty.
freq  out  32  last measured frequency in Hz.
freq_valid  out  1  one-cycle pulse when freq updates.

Behaviour:
Reset values (sys_rst=1 at a clock edge):
- All counters 0; gates 0; divider idle.
- freq=0, freq_valid=0, clk_out=0, synchronizer flops 0.

clk_out:
- Toggles each time the divider counter reaches CLK_OUT_DIV/2-1, then the counter clears.
- Default gives a 5 MHz output from 50 MHz.

Test-edge detect:
- clk_test passes through a 2-FF synchronizer plus a third flop.
- rise_pulse = sync2 & ~sync3, one cycle per clk_test rising edge (latency 2–3 cycles).

Period counter cnt_gate:
- Counts 0..CNT_GATE_S_MAX, then wraps to 0.
- gate_s = 1 when CNT_RISE_MAX <= cnt_gate < CNT_GATE_S_MAX-CNT_RISE_MAX; otherwise 0.

Real gate gate_a (updates only on rise_pulse):
- On rise_pulse: if gate_a==1 then X <= X+1; gate_a <= gate_s.
- Y <= Y+1 every cycle gate_a==1.
- Result: X = whole test periods in the gate; Y = sys cycles spanning exactly those periods.

Gate close (gate_a 1->0, detected with a registered copy):
- Latch X_lat=X, Y_lat=Y.
- Clear X, Y.
- Assert start to the divider.

Divider:
- Restoring shift-subtract, one quotient bit per cycle.
- Numerator = CLK_FREQ*X_lat (64-bit); denominator = Y_lat (32-bit); quotient truncated to 32 bits.
- Completes in at most 65 cycles after start.
- On done: freq <= quotient, freq_valid=1 for one cycle.
- If Y_lat==0: freq <= 0, with valid pulse.
- A start while busy is ignored; cannot happen with legal parameters.

No-signal handling:
- If cnt_gate wraps to 0 and no gate-close occurred during that period, then freq <= 0 with a valid pulse.
- This rule also applies when clk_test is stuck.

Frequency change:
- A change in clk_test mid-period affects only the measurement in progress.
- freq holds its old value until the next valid pulse.

Reset mid-measurement:
- Aborts everything; freq returns to 0.
- The first result appears after a full gate following reset.

Width rules:
- X and Y are 32-bit and saturate at all-ones; they do not wrap.
- With legal parameters, X*CLK_FREQ fits 64 bits.

Test Plan:
1. Override CNT_GATE_S_MAX=240, CNT_RISE_MAX=40. Hold sys_rst 10 cycles, then drive clk_test at 5 MHz (period 200 ns) starting 700 ns after sim start. -> X_lat=16, Y_lat=160; freq=5_000_000 with a one-cycle freq_valid pulse within 2 periods (~10 µs).
2. Same overrides, clk_test = 1 MHz. -> freq=1_000_000 on every subsequent period (each period is 241 cycles).
3. Same overrides, clk_test held 0. -> each period ends with freq_valid pulse and freq=0.
4. Same overrides, clk_test = 3.125 MHz (period 320 ns). -> freq within ±1 LSB of 3_125_000 (truncated quotient 3_125_000 when Y is a multiple of 16).
5. Check clk_out after reset release. -> 0 during reset, then toggles every 5 sys_clk cycles (period 200 ns = 5 MHz).
6. Assert sys_rst mid-gate for 3 cycles, after a valid result. -> freq=0 and freq_valid=0 during reset; the next valid result is correct (5_000_000 at 5 MHz).

Source files
------------

// File: rtl/freq_meter_top.sv
// Equal-precision frequency meter: edge-aligned gate counts whole test periods (X)
// and sys_clk cycles (Y), then divides CLK_FREQ*X by Y; also emits a divided test clock.
`timescale 1ns/1ps
module freq_meter_top #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned CNT_GATE_S_MAX = 74_999_999,
    parameter int unsigned CNT_RISE_MAX   = 12_499_999,
    parameter int unsigned CLK_OUT_DIV    = 10
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        clk_test,
    output logic        clk_out,
    output logic [31:0] freq,
    output logic        freq_valid
);
    localparam int unsigned DIV_W    = 16;
    localparam int unsigned DIV_LAST = CLK_OUT_DIV / 2 - 1;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned GATE_END = CNT_GATE_S_MAX - CNT_RISE_MAX;
    localparam int unsigned NUM_W    = 64;
    localparam int unsigned BIT_W    = 6;

    typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             sync1, sync2, sync3;
    logic [CNT_W-1:0] cnt_gate;
    logic             gate_a, gate_a_d, start;
    logic [31:0]      x, y, x_lat, y_lat;
    div_state_t       div_state;
    logic [NUM_W-1:0] num;
    logic [31:0]      rem;
    logic [BIT_W-1:0] bit_cnt;
    logic             got_close, deferred, zero_pend;

    logic             rise_pulse_c, wrap_c, gate_s_c, close_c;
    logic [32:0]      rem_shift_c, den_c;
    logic             sub_ok_c;
    logic [31:0]      rem_next_c;
    logic [NUM_W-1:0] num_next_c;
    logic             div_done_c, zero_div_c, zero_req_c;

    // Test clock output
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else if (div_cnt == DIV_W'(DIV_LAST)) begin
            div_cnt <= '0;
            clk_out <= ~clk_out;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // clk_test synchronizer and rising-edge detect
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk_test;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise_pulse_c = sync2 & ~sync3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)     cnt_gate <= '0;
        else if (wrap_c) cnt_gate <= '0;
        else             cnt_gate <= cnt_gate + CNT_W'(1);
    end

    assign wrap_c   = (cnt_gate == CNT_W'(CNT_GATE_S_MAX));
    assign gate_s_c = (cnt_gate >= CNT_W'(CNT_RISE_MAX)) && (cnt_gate < CNT_W'(GATE_END));
    assign close_c  = gate_a_d & ~gate_a;

    // Real gate and saturating X/Y counters; gate close hands the counts to the divider
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gate_a   <= 1'b0;
            gate_a_d <= 1'b0;
            start    <= 1'b0;
            x        <= '0;
            y        <= '0;
            x_lat    <= '0;
            y_lat    <= '0;
        end else begin
            gate_a_d <= gate_a;
            start    <= close_c;
            if (rise_pulse_c) gate_a <= gate_s_c;
            if (close_c) begin
                x_lat <= x;
                y_lat <= y;
                x     <= '0;
                y     <= '0;
            end else begin
                if (rise_pulse_c && gate_a && (x != '1)) x <= x + 32'd1;
                if (gate_a && (y != '1))                 y <= y + 32'd1;
            end
        end
    end

    // Restoring divider datapath: the dividend register shifts quotient bits in at the bottom
    assign rem_shift_c = {rem, num[NUM_W-1]};
    assign den_c       = {1'b0, y_lat};
    assign sub_ok_c    = (rem_shift_c >= den_c);
    assign rem_next_c  = sub_ok_c ? 32'(rem_shift_c - den_c) : rem_shift_c[31:0];
    assign num_next_c  = {num[NUM_W-2:0], sub_ok_c};

    assign div_done_c = (div_state == DIV_RUN) && (bit_cnt == '1);
    assign zero_div_c = (div_state == DIV_IDLE) && start && (y_lat == '0);
    // A gate still open at wrap gets one period of grace before it is reported as no-signal
    assign zero_req_c = wrap_c && !(got_close || close_c) && (deferred || !gate_a);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_state  <= DIV_IDLE;
            num        <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
            zero_pend  <= 1'b0;
            got_close  <= 1'b0;
            deferred   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (start && (y_lat != '0)) begin
                        num       <= NUM_W'(CLK_FREQ) * NUM_W'(x_lat);
                        rem       <= '0;
                        bit_cnt   <= '0;
                        div_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    num     <= num_next_c;
                    rem     <= rem_next_c;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == '1) div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase

            // Divider result wins a collision; a coincident no-signal report waits one cycle
            if (div_done_c || zero_div_c) begin
                freq       <= div_done_c ? num_next_c[31:0] : 32'd0;
                freq_valid <= 1'b1;
                if (zero_req_c) zero_pend <= 1'b1;
            end else if (zero_req_c || zero_pend) begin
                freq       <= '0;
                freq_valid <= 1'b1;
                zero_pend  <= 1'b0;
            end

            if (wrap_c) begin
                got_close <= 1'b0;
                if (got_close || close_c)  deferred <= 1'b0;
                else if (gate_a)           deferred <= 1'b1;
            end else if (close_c) begin
                got_close <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_top.sv
// Directed bench for freq_meter_top with a short measurement period (241 cycles).
`timescale 1ns/1ps
module tb_freq_meter_top;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        clk_test = 1'b0;
    logic        clk_out;
    logic [31:0] freq;
    logic        freq_valid;

    int tests = 0;
    int fails = 0;
    int half_ns = 0;

    freq_meter_top #(
        .CLK_FREQ      (50_000_000),
        .CNT_GATE_S_MAX(240),
        .CNT_RISE_MAX  (40),
        .CLK_OUT_DIV   (10)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clk_test  (clk_test),
        .clk_out   (clk_out),
        .freq      (freq),
        .freq_valid(freq_valid)
    );

    always #10 sys_clk = ~sys_clk;

    // Test clock edges stay on multiples of 20 ns, away from sys_clk rising edges
    always begin
        if (half_ns == 0) begin
            clk_test = 1'b0;
            #20;
        end else begin
            #(half_ns) clk_test = ~clk_test;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input int n);
        @(negedge sys_clk) sys_rst = 1'b1;
        repeat (n) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit got);
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge sys_clk);
            cycles++;
            if (freq_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            tests++;
            if ({freq_valid, clk_out, freq} !== 34'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: valid=%b clk_out=%b freq=%0d, want 0 0 0",
                         i, freq_valid, clk_out, freq);
            end
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_clk_out();
        logic exp;
        for (int n = 1; n <= 20; n++) begin
            @(negedge sys_clk);
            exp = ((n / 5) % 2) == 1;
            tests++;
            if (clk_out !== exp) begin
                fails++;
                $display("FAIL clk_out cycle %0d: got %b want %b", n, clk_out, exp);
            end
        end
    endtask

    task automatic test_5mhz();
        int  cyc;
        bit  got;
        if ($time < 700) #(700 - $time);
        half_ns = 100;
        wait_valid(600, cyc, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL 5mhz_first_valid: no valid within 600 cycles");
        end
        tests++;
        if (freq !== 32'd5_000_000) begin
            fails++;
            $display("FAIL 5mhz_freq: got %0d want 5000000", freq);
        end
        tests++;
        if (dut.x_lat !== 32'd16) begin
            fails++;
            $display("FAIL 5mhz_x_lat: got %0d want 16", dut.x_lat);
        end
        tests++;
        if (dut.y_lat !== 32'd160) begin
            fails++;
            $display("FAIL 5mhz_y_lat: got %0d want 160", dut.y_lat);
        end
        @(negedge sys_clk);
        tests++;
        if (freq_valid !== 1'b0) begin
            fails++;
            $display("FAIL 5mhz_valid_pulse_width: got %b want 0", freq_valid);
        end
        wait_valid(400, cyc, got);
        tests++;
        if (!got || freq !== 32'd5_000_000) begin
            fails++;
            $display("FAIL 5mhz_second: got=%b freq=%0d want 1 5000000", got, freq);
        end
    endtask

    task automatic test_1mhz();
        int cyc;
        bit got;
        half_ns = 500;
        apply_reset(3);
        for (int k = 0; k < 4; k++) begin
            wait_valid(400, cyc, got);
            tests++;
            if (!got || freq !== 32'd1_000_000) begin
                fails++;
                $display("FAIL 1mhz_result %0d: got=%b freq=%0d want 1 1000000", k, got, freq);
            end
        end
    endtask

    task automatic test_stuck();
        int cyc;
        bit got;
        half_ns = 0;
        repeat (30) @(negedge sys_clk);
        apply_reset(3);
        for (int k = 0; k < 3; k++) begin
            wait_valid(300, cyc, got);
            tests++;
            if (!got || freq !== 32'd0 || cyc != 241) begin
                fails++;
                $display("FAIL stuck_zero %0d: got=%b freq=%0d cycles=%0d want 1 0 241",
                         k, got, freq, cyc);
            end
        end
    endtask

    task automatic test_3125khz();
        int cyc;
        bit got;
        half_ns = 160;
        apply_reset(3);
        for (int k = 0; k < 2; k++) begin
            wait_valid(400, cyc, got);
            tests++;
            if (!got || freq !== 32'd3_125_000) begin
                fails++;
                $display("FAIL 3125khz_result %0d: got=%b freq=%0d want 1 3125000", k, got, freq);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit got;
        half_ns = 100;
        apply_reset(3);
        wait_valid(600, cyc, got);
        tests++;
        if (!got || freq !== 32'd5_000_000) begin
            fails++;
            $display("FAIL rstmid_before: got=%b freq=%0d want 1 5000000", got, freq);
        end
        repeat (80) @(negedge sys_clk);
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            tests++;
            if (freq !== 32'd0 || freq_valid !== 1'b0) begin
                fails++;
                $display("FAIL rstmid_in_reset %0d: freq=%0d valid=%b want 0 0", i, freq, freq_valid);
            end
        end
        sys_rst = 1'b0;
        wait_valid(600, cyc, got);
        tests++;
        if (!got || freq !== 32'd5_000_000) begin
            fails++;
            $display("FAIL rstmid_after: got=%b freq=%0d want 1 5000000", got, freq);
        end
        tests++;
        if (cyc < 200) begin
            fails++;
            $display("FAIL rstmid_latency: first result after %0d cycles, want >= 200", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_clk_out();
        test_5mhz();
        test_1mhz();
        test_stuck();
        test_3125khz();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
